// File: rtl/midi_tx_pkg.sv
// rtl/midi_tx_pkg.sv - shared MIDI types, widths and transmit FSM states
package midi_tx_pkg;

  localparam int CHANNEL_WIDTH = 4;
  localparam int DATA_WIDTH    = 7;
  localparam int BYTE_WIDTH    = 8;
  localparam int BAUD_RATE     = 31250;

  // Status nibbles as used throughout this codebase.
  typedef enum logic [3:0] {
    NOTE_ON        = 4'h8,
    NOTE_OFF       = 4'h9,
    CONTROL_CHANGE = 4'hB,
    PROGRAM_CHANGE = 4'hC
  } message_type_t;

  typedef struct packed {
    message_type_t         message_type;
    logic [DATA_WIDTH-1:0] data_byte1;
    logic [DATA_WIDTH-1:0] data_byte2;
  } message_t;

  // DROP is a one-cycle hold for accepted-but-unsupported messages.
  typedef enum logic [2:0] {
    IDLE,
    STATUS,
    DATA1,
    DATA2,
    DROP
  } tx_state_t;

  function automatic logic is_supported(input message_type_t t);
    logic ok;
    case (t)
      NOTE_ON, NOTE_OFF, CONTROL_CHANGE, PROGRAM_CHANGE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/midi_tx_uart_tx.sv
// rtl/midi_tx_uart_tx.sv - 8N1 byte serializer with back-to-back reload on stop completion
module uart_tx
  import midi_tx_pkg::BYTE_WIDTH;
#(
  parameter int BIT_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  tx
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(BYTE_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  uart_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [BYTE_WIDTH-1:0] shreg;
  logic                  bit_last;

  assign bit_last = (cnt == CNT_W'(BIT_CYCLES - 1));
  // done is combinational so the next byte can be loaded on the same edge the stop bit ends.
  assign done     = (state == STOP) && bit_last;
  assign ready    = (state == IDLE) || done;

  // Bit sequencer: load on handshake, then walk start, eight data bits LSB first, stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      shreg   <= data;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      state   <= START;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_last) begin
            cnt   <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            cnt <= '0;
            if (bit_idx == IDX_W'(BYTE_WIDTH - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI message transmitter: status/data byte sequencing over a UART line
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = midi_tx_pkg::BAUD_RATE,
  parameter int RUNNING_STATUS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  input  message_t                 message,
  input  logic [CHANNEL_WIDTH-1:0] channel,
  output logic                     tx,
  output logic                     busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  tx_state_t                state;
  tx_state_t                first_state;
  tx_state_t                after_state;
  tx_state_t                load_state;
  message_t                 msg_q;
  logic [CHANNEL_WIDTH-1:0] chan_q;
  message_t                 cur_msg;
  logic [CHANNEL_WIDTH-1:0] cur_chan;
  logic [BYTE_WIDTH-1:0]    status_byte;
  logic [BYTE_WIDTH-1:0]    last_status;
  logic                     last_valid;
  logic                     accept;
  logic [BYTE_WIDTH-1:0]    byte_data;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     ser_done;

  assign accept = msg_valid && msg_ready;

  // In IDLE the first byte is launched straight from the inputs so tx falls right after acceptance.
  always_comb begin
    cur_msg     = (state == IDLE) ? message : msg_q;
    cur_chan    = (state == IDLE) ? channel : chan_q;
    status_byte = {cur_msg.message_type, cur_chan};

    if (!is_supported(cur_msg.message_type)) begin
      first_state = DROP;
    end else if ((RUNNING_STATUS != 0) && last_valid && (last_status == status_byte)) begin
      first_state = DATA1;
    end else begin
      first_state = STATUS;
    end

    case (state)
      STATUS:  after_state = DATA1;
      DATA1:   after_state = (cur_msg.message_type == PROGRAM_CHANGE) ? IDLE : DATA2;
      default: after_state = IDLE;
    endcase

    case (state)
      IDLE:                 load_state = accept ? first_state : IDLE;
      STATUS, DATA1, DATA2: load_state = ser_done ? after_state : state;
      default:              load_state = IDLE;
    endcase

    byte_valid = 1'b0;
    byte_data  = '0;
    case (load_state)
      STATUS: begin
        byte_valid = 1'b1;
        byte_data  = status_byte;
      end
      DATA1: begin
        byte_valid = 1'b1;
        byte_data  = {1'b0, cur_msg.data_byte1};
      end
      DATA2: begin
        byte_valid = 1'b1;
        byte_data  = {1'b0, cur_msg.data_byte2};
      end
      default: begin
        byte_valid = 1'b0;
        byte_data  = '0;
      end
    endcase
  end

  // Message FSM with registered handshake/busy outputs and the running-status memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      msg_q       <= '{message_type: NOTE_ON, data_byte1: '0, data_byte2: '0};
      chan_q      <= '0;
      msg_ready   <= 1'b0;
      busy        <= 1'b0;
      last_status <= '0;
      last_valid  <= 1'b0;
    end else begin
      if (byte_valid && byte_ready && (load_state == STATUS)) begin
        last_status <= status_byte;
        last_valid  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            msg_q     <= message;
            chan_q    <= channel;
            msg_ready <= 1'b0;
            busy      <= (first_state != DROP);
            state     <= first_state;
          end else begin
            msg_ready <= 1'b1;
          end
        end
        DROP: begin
          state     <= IDLE;
          msg_ready <= 1'b1;
        end
        STATUS, DATA1, DATA2: begin
          if (ser_done) begin
            state <= after_state;
            if (after_state == IDLE) begin
              busy      <= 1'b0;
              msg_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          msg_ready <= 1'b0;
        end
      endcase
    end
  end

  uart_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (byte_data),
    .valid(byte_valid),
    .ready(byte_ready),
    .done (ser_done),
    .tx   (tx)
  );

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - directed self-checking bench for midi_tx at 10 clk cycles per bit
module tb_midi_tx;
  import midi_tx_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       msg_valid;
  logic       msg_ready;
  message_t   message;
  logic [3:0] channel;
  logic       tx;
  logic       busy;

  int total;
  int bad;
  int frame_bad;
  int low_cnt;
  logic [7:0] rx;

  midi_tx #(
    .CLK_FREQ      (312500),
    .BAUD_RATE     (31250),
    .RUNNING_STATUS(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .message  (message),
    .channel  (channel),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a message with valid high and step to the negedge after the accept edge.
  task automatic offer(input logic [3:0] t, input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2);
    message   = '{message_type: message_type_t'(t), data_byte1: d1, data_byte2: d2};
    channel   = ch;
    msg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mon();
    if (busy !== 1'b1 || msg_ready !== 1'b0) frame_bad++;
  endtask

  // Called at the negedge in cycle 0 of a start bit; returns at cycle 0 of the following bit period.
  task automatic rx_byte(output logic [7:0] b);
    repeat (5) @(negedge clk);
    if (tx !== 1'b0) frame_bad++;
    mon();
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = tx;
      mon();
    end
    repeat (10) @(negedge clk);
    if (tx !== 1'b1) frame_bad++;
    mon();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    frame_bad = 0;
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    message   = '{message_type: NOTE_ON, data_byte1: '0, data_byte2: '0};
    channel   = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", msg_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", msg_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", msg_ready, 1'b1);

    // NOTE_ON ch3 0x3C 0x64
    offer(4'h8, 4'h3, 7'h3C, 7'h64);
    msg_valid = 1'b0;
    chk("non_start", tx, 1'b0);
    chk("non_busy", busy, 1'b1);
    chk("non_ready_low", msg_ready, 1'b0);
    rx_byte(rx); chk("non_b0", rx, 8'h83);
    chk("non_b2b1", tx, 1'b0);
    rx_byte(rx); chk("non_b1", rx, 8'h3C);
    chk("non_b2b2", tx, 1'b0);
    rx_byte(rx); chk("non_b2", rx, 8'h64);
    chk("non_end_ready", msg_ready, 1'b1);
    chk("non_end_busy", busy, 1'b0);
    chk("non_end_tx", tx, 1'b1);
    chk("non_frames", frame_bad, 0);

    // PROGRAM_CHANGE ch0 prog 5: two frames only
    frame_bad = 0;
    offer(4'hC, 4'h0, 7'h05, 7'h00);
    msg_valid = 1'b0;
    rx_byte(rx); chk("pc_b0", rx, 8'hC0);
    rx_byte(rx); chk("pc_b1", rx, 8'h05);
    chk("pc_end_ready", msg_ready, 1'b1);
    chk("pc_end_busy", busy, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1) low_cnt++;
      @(negedge clk);
    end
    chk("pc_no_third", low_cnt, 0);
    chk("pc_frames", frame_bad, 0);

    // Running status: CC ch2 twice, second drops its status byte
    frame_bad = 0;
    offer(4'hB, 4'h2, 7'd24, 7'd10);
    msg_valid = 1'b0;
    rx_byte(rx); chk("cc1_b0", rx, 8'hB2);
    rx_byte(rx); chk("cc1_b1", rx, 8'h18);
    rx_byte(rx); chk("cc1_b2", rx, 8'h0A);
    offer(4'hB, 4'h2, 7'd25, 7'd99);
    msg_valid = 1'b0;
    rx_byte(rx); chk("cc2_b0", rx, 8'h19);
    rx_byte(rx); chk("cc2_b1", rx, 8'h63);
    chk("cc2_end_ready", msg_ready, 1'b1);
    chk("cc_frames", frame_bad, 0);

    // Unsupported type 4'hE: handshake only, no bytes, last-status untouched
    offer(4'hE, 4'h2, 7'h11, 7'h22);
    msg_valid = 1'b0;
    chk("drop_ready_low", msg_ready, 1'b0);
    chk("drop_busy", busy, 1'b0);
    chk("drop_tx", tx, 1'b1);
    @(negedge clk);
    chk("drop_ready_back", msg_ready, 1'b1);
    chk("drop_tx2", tx, 1'b1);
    frame_bad = 0;
    offer(4'hB, 4'h2, 7'd26, 7'd7);
    msg_valid = 1'b0;
    rx_byte(rx); chk("cc3_b0", rx, 8'h1A);
    rx_byte(rx); chk("cc3_b1", rx, 8'h07);
    chk("cc3_frames", frame_bad, 0);

    // NOTE_OFF aborted by reset at cycle 45 (inside bit3 = 0)
    offer(4'h9, 4'h1, 7'h40, 7'h20);
    msg_valid = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_pre_tx", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", msg_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", msg_ready, 1'b1);
    frame_bad = 0;
    offer(4'h9, 4'h1, 7'h40, 7'h20);
    msg_valid = 1'b0;
    rx_byte(rx); chk("noff_b0", rx, 8'h91);
    rx_byte(rx); chk("noff_b1", rx, 8'h40);
    rx_byte(rx); chk("noff_b2", rx, 8'h20);
    chk("noff_frames", frame_bad, 0);

    // Three queued messages with msg_valid held high
    frame_bad = 0;
    offer(4'hC, 4'h4, 7'h01, 7'h00);
    chk("q1_start", tx, 1'b0);
    message = '{message_type: PROGRAM_CHANGE, data_byte1: 7'h02, data_byte2: 7'h00};
    channel = 4'h5;
    rx_byte(rx); chk("q1_b0", rx, 8'hC4);
    rx_byte(rx); chk("q1_b1", rx, 8'h01);
    chk("q1_accept_ready", msg_ready, 1'b1);
    chk("q1_gap_tx", tx, 1'b1);
    @(negedge clk);
    chk("q2_start", tx, 1'b0);
    chk("q2_ready_low", msg_ready, 1'b0);
    message = '{message_type: PROGRAM_CHANGE, data_byte1: 7'h03, data_byte2: 7'h00};
    channel = 4'h4;
    rx_byte(rx); chk("q2_b0", rx, 8'hC5);
    rx_byte(rx); chk("q2_b1", rx, 8'h02);
    chk("q2_accept_ready", msg_ready, 1'b1);
    chk("q2_gap_tx", tx, 1'b1);
    @(negedge clk);
    msg_valid = 1'b0;
    chk("q3_start", tx, 1'b0);
    rx_byte(rx); chk("q3_b0", rx, 8'hC4);
    rx_byte(rx); chk("q3_b1", rx, 8'h03);
    chk("q3_end_ready", msg_ready, 1'b1);
    chk("q3_end_busy", busy, 1'b0);
    chk("q_frames", frame_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD_RATE, default MIDI::BAUD_RATE (31250), meaning the serial bit rate.
REQ-003 SHALL provide parameter RUNNING_STATUS, default 0, meaning that 1 enables MIDI running-status byte suppression.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge on clk.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port msg_valid, input, 1 bit: a message is offered.
REQ-007 SHALL have port msg_ready, output, 1 bit: the block accepts a message this cycle.
REQ-008 SHALL have port message, input, MIDI::message_t (4+7+7 bits): message type and two 7-bit data fields.
REQ-009 SHALL have port channel, input, MIDI::CHANNEL_WIDTH (4) bits: the MIDI channel for the status byte.
REQ-010 SHALL have port tx, output, 1 bit: the UART serial line, which idles high.
REQ-011 SHALL have port busy, output, 1 bit: high while any byte of an accepted message remains unsent.

Function
REQ-012 SHALL complete a transfer on a clk edge where msg_valid and msg_ready are both high, capturing message and channel on that edge.
REQ-013 SHALL drive msg_ready high only in state IDLE while no frame is in progress, and low in every other state.
REQ-014 SHALL build the status byte as {message_type, channel}, using the MIDI package encodings unchanged.
REQ-015 SHALL build data bytes as {1'b0, data_byteN[6:0]}.
REQ-016 SHALL map message types to byte sequences as follows:
- NOTE_ON, NOTE_OFF and CONTROL_CHANGE: status, data1, data2.
- PROGRAM_CHANGE: status, data1.
REQ-017 SHALL accept any other message_type (complete the handshake) and emit no bytes, returning to IDLE on the next cycle.
REQ-018 SHALL sequence transmission with the FSM states IDLE -> STATUS -> DATA1 -> DATA2 -> IDLE, skipping DATA2 for PROGRAM_CHANGE.
REQ-019 SHALL leave each FSM state only when the byte serializer reports that the stop bit has completed.
REQ-020 SHALL frame every byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with each bit lasting BIT_CYCLES = CLK_FREQ/BAUD_RATE clk cycles (integer division).
REQ-021 SHALL make tx fall (start bit) on the cycle after acceptance, i.e. a latency of 1 cycle.
REQ-022 SHALL send consecutive bytes of a message back-to-back, with no idle bit between frames.
REQ-023 SHALL, when RUNNING_STATUS=1, omit the status byte when it equals the last transmitted status byte, going directly to DATA1.
REQ-024 SHALL update the last-status register only when a status byte is actually sent.
REQ-025 SHALL clear the last-status register on reset and never update it for dropped messages.
REQ-026 SHALL assert busy from the cycle after acceptance until the final stop bit completes; busy and msg_ready are never both high.
REQ-027 SHALL size the bit-period counter to $clog2(BIT_CYCLES) bits and reload it on every bit boundary, with no drift.

Reset
REQ-028 SHALL on rst_n low immediately force tx=1, msg_ready=0, busy=0, FSM=IDLE, serializer idle, counters=0 and last-status=invalid.
REQ-029 SHALL abort any frame in progress on reset, including mid-frame, with no glitch low on tx.
REQ-030 SHALL assert msg_ready on the first clk edge after rst_n deasserts.

Structure
REQ-031 SHALL take message_type_t, message_t, CHANNEL_WIDTH, DATA_WIDTH and BAUD_RATE from the shared MIDI package; the FSM state enum and the BYTE_WIDTH usage live in that package/CONFIG.
REQ-032 SHALL instantiate exactly one sub-module, uart_tx: a byte serializer with data/valid/ready, a done pulse, and tx, using its own IDLE/START/DATA/STOP states.

Verification (CLK_FREQ=312500, BAUD_RATE=31250 -> 10 cycles/bit)
REQ-033 SHALL cover: NOTE_ON, channel 3, note 0x3C, velocity 0x64 -> tx bytes 0x83, 0x3C, 0x64, 300 cycles total, busy high throughout, msg_ready high the cycle after the final stop bit.
REQ-034 SHALL cover: PROGRAM_CHANGE, channel 0, program 5 -> bytes 0xC0, 0x05, 200 cycles, with no third frame.
REQ-035 SHALL cover: RUNNING_STATUS=1, two CONTROL_CHANGE messages on channel 2 (ctrl 24 val 10, then ctrl 25 val 99) -> 0xB2, 0x18, 0x0A, then only 0x19, 0x63.
REQ-036 SHALL cover: message_type 4'hE with valid high -> handshake completes, tx stays 1, msg_ready high again 2 cycles later.
REQ-037 SHALL cover: rst_n pulsed low at cycle 45 of a NOTE_OFF frame -> tx=1 at once, busy=0, and the next message transmits normally with its status byte (last-status cleared).
REQ-038 SHALL cover: msg_valid held high continuously with three queued messages -> each is accepted only while IDLE, and the frames are separated by exactly one accept cycle.
